// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 receive path (and the transmit path that
// reuses the clock filter): receiver FSM state encoding, frame length and
// default timing constants.
// Optional build macro used by ps2_rx: PS2_RX_TIMEOUT_EN.
// -----------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } rx_state_e;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_BITS = 11;

  localparam int PS2_FILTER_LEN_DEF = 8;
  localparam int PS2_TIMEOUT_DEF    = 200000;

endpackage

// File: rtl/ps2_clk_filter.sv
// -----------------------------------------------------------------------------
// ps2_clk_filter
// Two-flop synchronisers on the PS/2 clock and data lines, a glitch filter on
// the clock line and a registered falling-edge detector. Shared by the
// receive and transmit paths.
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-low reset
//   i_ps2_c     in   raw PS/2 clock line
//   i_ps2_d     in   raw PS/2 data line
//   o_c_filt    out  filtered PS/2 clock
//   o_d_sync    out  synchronised PS/2 data
//   o_fall_edge out  one-cycle pulse on each filtered clock falling edge
// -----------------------------------------------------------------------------
module ps2_clk_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = PS2_FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_ps2_c,
  input  logic i_ps2_d,
  output logic o_c_filt,
  output logic o_d_sync,
  output logic o_fall_edge
);

  logic                  r_c_meta;
  logic                  r_c_sync;
  logic                  r_d_meta;
  logic                  r_d_sync;
  logic [FILTER_LEN-1:0] r_samples;
  logic                  r_c_filt;
  logic                  r_fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_c_meta  <= 1'b1;
      r_c_sync  <= 1'b1;
      r_d_meta  <= 1'b1;
      r_d_sync  <= 1'b1;
      r_samples <= '1;
      r_c_filt  <= 1'b1;
      r_fall    <= 1'b0;
    end else begin
      r_c_meta  <= i_ps2_c;
      r_c_sync  <= r_c_meta;
      r_d_meta  <= i_ps2_d;
      r_d_sync  <= r_d_meta;
      r_samples <= {r_samples[FILTER_LEN-2:0], r_c_sync};
      // The filtered clock only moves on a full window of agreeing samples;
      // the edge pulse is registered together with the 1->0 transition.
      if (r_samples == '0) begin
        r_c_filt <= 1'b0;
        r_fall   <= r_c_filt;
      end else begin
        r_fall <= 1'b0;
        if (&r_samples) r_c_filt <= 1'b1;
      end
    end
  end

  assign o_c_filt    = r_c_filt;
  assign o_d_sync    = r_d_sync;
  assign o_fall_edge = r_fall;

endmodule

// File: rtl/ps2_rx.sv
// -----------------------------------------------------------------------------
// ps2_rx
// PS/2 device-to-host receiver. Deframes start, 8 data bits (LSB first), odd
// parity and stop; presents the byte with a one-cycle rx_done strobe and
// parity/framing error flags that are held until the next completed frame.
//
// Build macro: PS2_RX_TIMEOUT_EN -- when defined, a frame that sees no
// falling edge for TIMEOUT_CYCLES clocks is abandoned silently. When not
// defined the receiver waits indefinitely for the remaining edges.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   ps2_c      in   raw PS/2 clock line
//   ps2_d      in   raw PS/2 data line
//   rx_en      in   1 = new frames may start; 0 = start bits are ignored
//   fall_edge  out  one-cycle pulse per filtered ps2_c falling edge
//   dout       out  last received byte
//   rx_done    out  one-cycle pulse when a frame completes
//   parity_err out  parity error of the last completed frame
//   frame_err  out  stop bit of the last completed frame was 0
//   rx_busy    out  receiver is inside a frame
// -----------------------------------------------------------------------------
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = PS2_FILTER_LEN_DEF,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_c,
  input  logic       ps2_d,
  input  logic       rx_en,
  output logic       fall_edge,
  output logic [7:0] dout,
  output logic       rx_done,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);

  // Bits captured after the start bit: 8 data, parity, stop.
  localparam int SR_W = PS2_FRAME_BITS - 1;

  logic            w_fall;
  logic            w_d_sync;

  rx_state_e       r_state;
  logic [3:0]      r_cnt;
  logic [SR_W-1:0] r_sr;
  logic [7:0]      r_dout;
  logic            r_done;
  logic            r_perr;
  logic            r_ferr;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] r_timer;
`endif

  ps2_clk_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk         (clk),
    .rst         (rst),
    .i_ps2_c     (ps2_c),
    .i_ps2_d     (ps2_d),
    .o_c_filt    (),
    .o_d_sync    (w_d_sync),
    .o_fall_edge (w_fall)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_sr    <= '0;
      r_dout  <= 8'h00;
      r_done  <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
      r_timer <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_fall && rx_en && !w_d_sync) begin
            r_cnt   <= 4'd0;
`ifdef PS2_RX_TIMEOUT_EN
            r_timer <= '0;
`endif
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_fall) begin
            // LSB arrives first, so after all bits: [7:0] data, [8] parity, [9] stop.
            r_sr  <= {w_d_sync, r_sr[SR_W-1:1]};
            r_cnt <= r_cnt + 4'd1;
`ifdef PS2_RX_TIMEOUT_EN
            r_timer <= '0;
`endif
            if (r_cnt == 4'(SR_W - 1)) r_state <= DONE;
          end
`ifdef PS2_RX_TIMEOUT_EN
          else if (r_timer == TMR_W'(TIMEOUT_CYCLES)) begin
            r_state <= IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
`endif
        end
        DONE: begin
          r_dout  <= r_sr[7:0];
          r_perr  <= ~(^r_sr[8:0]);
          r_ferr  <= ~r_sr[9];
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign fall_edge  = w_fall;
  assign dout       = r_dout;
  assign rx_done    = r_done;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign rx_busy    = (r_state != IDLE);

endmodule
